// File: rtl/fetch_unit.sv
// ============================================================================
// Module  : fetch_unit
// Summary : Instruction-fetch stage: owns the PC, drives instruction memory and
//           queues {pc, insn, fault} entries for decode over valid/ready.
//           Optional macro FETCH_HALT_ON_ECALL_EN adds halt-on-ecall/ebreak.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h01000000,
  parameter logic [31:0] MEM_BYTES = 32'h00100000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  output logic [31:0] imem_data_in,
  output logic        imem_read_write,
  input  logic [31:0] imem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_insn,
  output logic        out_fault
`ifdef FETCH_HALT_ON_ECALL_EN
  ,
  output logic        halted
`endif
);

  localparam int unsigned c_PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(BUF_DEPTH);

  logic [31:0]        pc_q, pc_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_CNT_W-1:0] count_q, count_d;

  logic [31:0] ent_pc_q    [BUF_DEPTH];
  logic [31:0] ent_insn_q  [BUF_DEPTH];
  logic        ent_fault_q [BUF_DEPTH];

  logic        w_deq;
  logic        w_run;
  logic        w_fetch;
  logic        w_fault;
  logic [31:0] w_pc_off;

  assign imem_address    = pc_q;
  assign imem_data_in    = 32'h0;
  assign imem_read_write = 1'b0;

  // Offset is only meaningful when pc >= RESET_PC; the lower bound covers the rest.
  assign w_pc_off = pc_q - RESET_PC;
  assign w_fault  = (pc_q[1:0] != 2'b00) | (pc_q < RESET_PC) | (w_pc_off >= MEM_BYTES);

  assign out_valid = (count_q != '0);
  assign w_deq     = out_valid & out_ready;
  assign w_fetch   = ((count_q < c_DEPTH) | w_deq) & ~redirect_valid & w_run;

`ifdef FETCH_HALT_ON_ECALL_EN
  localparam logic [0:0] c_ST_RUN    = 1'b0;
  localparam logic [0:0] c_ST_HALTED = 1'b1;

  logic [0:0] state_q, state_d;
  logic       w_is_sys;

  assign w_is_sys = (imem_data_out == 32'h00000073) | (imem_data_out == 32'h00100073);
  assign w_run    = (state_q == c_ST_RUN);
  assign halted   = (state_q == c_ST_HALTED);

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_RUN: begin
        if (w_fetch && w_is_sys) begin
          state_d = c_ST_HALTED;
        end
      end
      c_ST_HALTED: begin
        if (redirect_valid) begin
          state_d = c_ST_RUN;
        end
      end
      default: state_d = c_ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= c_ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign w_run = 1'b1;
`endif

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      // A dequeue in this cycle still counts as consumed; the flush drops the rest.
      pc_d     = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_fetch) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
      end
      if (w_deq) begin
        rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
      end
      if (w_fetch && !w_deq) begin
        count_d = count_q + c_CNT_W'(1);
      end else if (!w_fetch && w_deq) begin
        count_d = count_q - c_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: outputs are gated by out_valid.
  always_ff @(posedge clock) begin
    if (reset && w_fetch) begin
      ent_pc_q[wr_ptr_q]    <= pc_q;
      ent_insn_q[wr_ptr_q]  <= imem_data_out;
      ent_fault_q[wr_ptr_q] <= w_fault;
    end
  end

  assign out_pc    = out_valid ? ent_pc_q[rd_ptr_q]    : 32'h0;
  assign out_insn  = out_valid ? ent_insn_q[rd_ptr_q]  : 32'h0;
  assign out_fault = out_valid ? ent_fault_q[rd_ptr_q] : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module  : tb_fetch_unit
// Summary : Directed vector bench for fetch_unit with a combinational imem model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] R = 32'h01000000;
  localparam logic [31:0] M = 32'h00100000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_address;
  logic [31:0] imem_data_in;
  logic        imem_read_write;
  logic [31:0] imem_data_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_insn;
  logic        out_fault;
`ifdef FETCH_HALT_ON_ECALL_EN
  logic        halted;
`endif
  logic        ecall_on;

  int n_vec;
  int n_miss;

  fetch_unit #(.RESET_PC(R), .MEM_BYTES(M), .BUF_DEPTH(2)) dut (
    .clock          (clk),
    .reset          (rst_n),
    .imem_address   (imem_address),
    .imem_data_in   (imem_data_in),
    .imem_read_write(imem_read_write),
    .imem_data_out  (imem_data_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_insn       (out_insn),
    .out_fault      (out_fault)
`ifdef FETCH_HALT_ON_ECALL_EN
    ,
    .halted         (halted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic ec);
    if (a == R)                      return 32'h00000013;
    if (a == R + 32'd4)              return 32'h00500093;
    if (ec && (a == R + 32'hC))      return 32'h00000073;
    return a ^ 32'hDEAD0013;
  endfunction

  assign imem_data_out = mem_word(imem_address, ecall_on);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance past the edge.
  task automatic cyc(input string tag, input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic ev, input logic [31:0] epc, input logic ef,
                     input logic [31:0] eaddr, input logic eh);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(negedge clk);
    chk({tag, " valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({tag, " pc"},    out_pc, ev ? epc : 32'h0);
    chk({tag, " insn"},  out_insn, ev ? mem_word(epc, ecall_on) : 32'h0);
    chk({tag, " fault"}, {31'd0, out_fault}, {31'd0, ev & ef});
    chk({tag, " addr"},  imem_address, eaddr);
`ifdef FETCH_HALT_ON_ECALL_EN
    chk({tag, " halted"}, {31'd0, halted}, {31'd0, eh});
`else
    if (eh) chk({tag, " halted-unused"}, 32'd0, {31'd0, eh});
`endif
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic        ef;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tv [35];

  initial begin
    n_vec = 0;
    n_miss = 0;
    ecall_on = 1'b0;

    //         rv  rpc              rdy ev  epc               ef  eaddr
    tv[0]  = '{0, 32'h0,           1, 0, 32'h0,            0, R};
    tv[1]  = '{0, 32'h0,           1, 1, R,                0, R + 32'h4};
    tv[2]  = '{0, 32'h0,           0, 1, R + 32'h4,        0, R + 32'h8};
    tv[3]  = '{0, 32'h0,           0, 1, R + 32'h4,        0, R + 32'hC};
    tv[4]  = '{0, 32'h0,           0, 1, R + 32'h4,        0, R + 32'hC};
    tv[5]  = '{0, 32'h0,           0, 1, R + 32'h4,        0, R + 32'hC};
    tv[6]  = '{0, 32'h0,           0, 1, R + 32'h4,        0, R + 32'hC};
    tv[7]  = '{0, 32'h0,           1, 1, R + 32'h4,        0, R + 32'hC};
    tv[8]  = '{0, 32'h0,           1, 1, R + 32'h8,        0, R + 32'h10};
    tv[9]  = '{0, 32'h0,           1, 1, R + 32'hC,        0, R + 32'h14};
    tv[10] = '{0, 32'h0,           0, 1, R + 32'h10,       0, R + 32'h18};
    tv[11] = '{1, R + 32'h100,     0, 1, R + 32'h10,       0, R + 32'h18};
    tv[12] = '{0, 32'h0,           1, 0, 32'h0,            0, R + 32'h100};
    tv[13] = '{0, 32'h0,           1, 1, R + 32'h100,      0, R + 32'h104};
    tv[14] = '{1, R + 32'h102,     1, 1, R + 32'h104,      0, R + 32'h108};
    tv[15] = '{0, 32'h0,           1, 0, 32'h0,            0, R + 32'h102};
    tv[16] = '{1, 32'h00FFFFFC,    1, 1, R + 32'h102,      1, R + 32'h106};
    tv[17] = '{0, 32'h0,           1, 0, 32'h0,            0, 32'h00FFFFFC};
    tv[18] = '{1, R + M,           1, 1, 32'h00FFFFFC,     1, R};
    tv[19] = '{0, 32'h0,           1, 0, 32'h0,            0, R + M};
    tv[20] = '{1, R + 32'h10,      1, 1, R + M,            1, R + M + 32'h4};
    tv[21] = '{0, 32'h0,           1, 0, 32'h0,            0, R + 32'h10};
    tv[22] = '{1, R + M - 32'h4,   1, 1, R + 32'h10,       0, R + 32'h14};
    tv[23] = '{0, 32'h0,           1, 0, 32'h0,            0, R + M - 32'h4};
    tv[24] = '{0, 32'h0,           1, 1, R + M - 32'h4,    0, R + M};
    tv[25] = '{0, 32'h0,           1, 1, R + M,            1, R + M + 32'h4};
    tv[26] = '{1, R + 32'h200,     0, 1, R + M + 32'h4,    1, R + M + 32'h8};
    tv[27] = '{1, R + 32'h300,     0, 0, 32'h0,            0, R + 32'h200};
    tv[28] = '{0, 32'h0,           0, 0, 32'h0,            0, R + 32'h300};
    tv[29] = '{0, 32'h0,           0, 1, R + 32'h300,      0, R + 32'h304};
    tv[30] = '{1, R,               0, 1, R + 32'h300,      0, R + 32'h308};
    tv[31] = '{1, 32'hFFFFFFFC,    1, 0, 32'h0,            0, R};
    tv[32] = '{0, 32'h0,           1, 0, 32'h0,            0, 32'hFFFFFFFC};
    tv[33] = '{0, 32'h0,           1, 1, 32'hFFFFFFFC,     1, 32'h0};
    tv[34] = '{0, 32'h0,           1, 1, 32'h0,            1, 32'h4};

    // Reset held with a redirect pending: reset must win.
    rst_n = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h12345678;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst valid", {31'd0, out_valid}, 32'd0);
    chk("rst pc",    out_pc, 32'h0);
    chk("rst insn",  out_insn, 32'h0);
    chk("rst fault", {31'd0, out_fault}, 32'd0);
    chk("rst addr",  imem_address, R);
    chk("rst wdata", imem_data_in, 32'h0);
    chk("rst rw",    {31'd0, imem_read_write}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 35; i++) begin
      cyc($sformatf("v%0d", i), tv[i].rv, tv[i].rpc, tv[i].rdy,
          tv[i].ev, tv[i].epc, tv[i].ef, tv[i].eaddr, 1'b0);
    end

    // Mid-operation reset with redirect and ready asserted discards everything.
    rst_n = 1'b0;
    cyc("mrst0", 1'b1, R + 32'h500, 1'b1, 1'b1, 32'h4, 1'b1, 32'h8, 1'b0);
    rst_n = 1'b1;
    cyc("mrst1", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, R, 1'b0);
    cyc("mrst2", 1'b0, 32'h0, 1'b0, 1'b1, R, 1'b0, R + 32'h4, 1'b0);

`ifdef FETCH_HALT_ON_ECALL_EN
    ecall_on = 1'b1;
    rst_n = 1'b0;
    cyc("h_rst", 1'b0, 32'h0, 1'b1, 1'b1, R, 1'b0, R + 32'h8, 1'b0);
    rst_n = 1'b1;
    cyc("h0",  1'b0, 32'h0, 1'b1, 1'b0, 32'h0,      1'b0, R,           1'b0);
    cyc("h1",  1'b0, 32'h0, 1'b1, 1'b1, R,          1'b0, R + 32'h4,   1'b0);
    cyc("h2",  1'b0, 32'h0, 1'b1, 1'b1, R + 32'h4,  1'b0, R + 32'h8,   1'b0);
    cyc("h3",  1'b0, 32'h0, 1'b1, 1'b1, R + 32'h8,  1'b0, R + 32'hC,   1'b0);
    cyc("h4",  1'b0, 32'h0, 1'b1, 1'b1, R + 32'hC,  1'b0, R + 32'h10,  1'b1);
    cyc("h5",  1'b0, 32'h0, 1'b1, 1'b0, 32'h0,      1'b0, R + 32'h10,  1'b1);
    cyc("h6",  1'b0, 32'h0, 1'b1, 1'b0, 32'h0,      1'b0, R + 32'h10,  1'b1);
    cyc("h7",  1'b1, R,     1'b1, 1'b0, 32'h0,      1'b0, R + 32'h10,  1'b1);
    cyc("h8",  1'b0, 32'h0, 1'b1, 1'b0, 32'h0,      1'b0, R,           1'b0);
    cyc("h9",  1'b0, 32'h0, 1'b1, 1'b1, R,          1'b0, R + 32'h4,   1'b0);
    cyc("h10", 1'b0, 32'h0, 1'b1, 1'b1, R + 32'h4,  1'b0, R + 32'h8,   1'b0);
    cyc("h11", 1'b0, 32'h0, 1'b1, 1'b1, R + 32'h8,  1'b0, R + 32'hC,   1'b0);
    cyc("h12", 1'b0, 32'h0, 1'b0, 1'b1, R + 32'hC,  1'b0, R + 32'h10,  1'b1);
    rst_n = 1'b0;
    cyc("h13", 1'b0, 32'h0, 1'b0, 1'b1, R + 32'hC,  1'b0, R + 32'h10,  1'b1);
    rst_n = 1'b1;
    cyc("h14", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,      1'b0, R,           1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the PC and drives the memory's address, data_in and read_write inputs; the memory's read data returns combinationally in the same cycle.
- Captures each {pc, instruction} pair into a small FIFO that feeds decode over a valid/ready handshake.
- Accepts a redirect from execute (branch/jump), which flushes all in-flight fetches.

Parameters:
- RESET_PC, 32'h01000000, PC loaded on reset; base of instruction memory.
- MEM_BYTES, 32'h00100000, size of instruction memory in bytes; used for range checking.
- BUF_DEPTH, 2, FIFO entries; power of two, minimum 2.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low.
- imem_address  output  32  byte address to instruction memory; always equals pc.
- imem_data_in  output  32  write data to memory; constant 0.
- imem_read_write  output  1  memory write enable; constant 0.
- imem_data_out  input  32  instruction from memory, valid in the same cycle.
- redirect_valid  input  1  one-cycle request to load a new PC.
- redirect_pc  input  32  target PC for the redirect.
- out_valid  output  1  FIFO head holds a valid entry.
- out_ready  input  1  decode accepts the head this cycle.
- out_pc  output  32  PC of the head entry.
- out_insn  output  32  instruction of the head entry.
- out_fault  output  1  head entry was fetched from a misaligned or out-of-range PC.

Behaviour:
- Reset, sampled on the rising edge while reset==0:
  - pc<=RESET_PC; FIFO read pointer, write pointer and count <=0.
  - Outputs: out_valid=0; out_pc, out_insn and out_fault read as 0 while empty.
- Dequeue: deq = out_valid & out_ready.
- Fetch-enable: fetch = (count<BUF_DEPTH | deq) & !redirect_valid.
  - Dequeue and enqueue may occur in the same cycle when full.
- On fetch:
  - Push {pc, imem_data_out, fault} at the write pointer.
  - fault = (pc[1:0]!=0) | (pc<RESET_PC) | (pc-RESET_PC >= MEM_BYTES).
  - pc<=pc+4, 32-bit wrap-around. No wrap check beyond the fault flag.
- Pointers wrap modulo BUF_DEPTH. Count changes by +1 on push only, −1 on pop only, unchanged on both.
- Fault entries carry imem_data_out unmodified, and fetching continues. Decode is responsible for the trap.
- Redirect has priority over everything:
  - Next edge: pc<=redirect_pc; FIFO flushed (count<=0, pointers<=0).
  - No push that cycle; any dequeue that cycle is still considered consumed by decode.
  - Redirect while empty or full behaves identically.
  - Back-to-back redirects: the last one wins.
- Latency: PC presented in cycle N → entry at the head in cycle N+1 if the FIFO was empty.
  - Throughput: 1 instruction/cycle while out_ready=1.
- Head entry and outputs are stable while out_valid=1 and out_ready=0, with no redirect.
- out_valid=(count!=0), registered-state-derived. No combinational path from out_ready to out_valid.
- Reset mid-operation discards all entries and the PC regardless of redirect_valid or out_ready.

Optional Feature:
- Macro FETCH_HALT_ON_ECALL_EN.
- Defined:
  - Two-state FSM, RUN and HALTED; reset→RUN.
  - In RUN, when a fetched word equals 32'h00000073 (ecall) or 32'h00100073 (ebreak): push it normally, pc<=pc+4, next state HALTED.
  - In HALTED: fetch=0, pc held, FIFO drains normally.
  - redirect_valid in HALTED → pc<=redirect_pc, flush, RUN.
  - Extra output halted (1 bit, =1 in HALTED; reset 0).
- Undefined: no FSM and no halted port; ecall/ebreak are fetched like any other word.

Test Plan:
- Reset release, out_ready=1, memory words 0x00000013, 0x00500093, ... → out_pc 0x01000000, 0x01000004, 0x01000008 on consecutive cycles; first out_valid the cycle after reset deasserts.
- out_ready=0 for 5 cycles → count saturates at 2, pc stops at 0x01000008, head stays 0x01000000; then out_ready=1 → no entry lost or duplicated.
- FIFO full with out_ready=1 → simultaneous push and pop; count stays 2, one instruction/cycle.
- redirect_valid with redirect_pc=0x01000100 while full → next cycle out_valid=0; following cycle out_pc=0x01000100; old entries never appear.
- redirect_pc=0x01000102, then redirect_pc=0x00FFFFFC, then redirect_pc=RESET_PC+MEM_BYTES → out_fault=1 on each; redirect to 0x01000010 → out_fault=0.
- With FETCH_HALT_ON_ECALL_EN, 0x00000073 at 0x0100000C → entry delivered, halted=1, pc=0x01000010 held; redirect to 0x01000000 → halted=0, fetch resumes. Assert reset while halted → RUN, pc=RESET_PC.
